// File: rtl/mem_reader_pkg.sv
// Shared constants and state type for the data-memory read side.
package mem_reader_pkg;

  localparam int WORD_W    = 8;
  localparam int NUM_WORDS = 16;
  localparam int ADDR_W    = 4;
  localparam int MEM_W     = NUM_WORDS * WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of words in an inclusive, wrapping address range (1..NUM_WORDS).
  function automatic logic [ADDR_W:0] range_len(input logic [ADDR_W-1:0] first,
                                                 input logic [ADDR_W-1:0] last);
    logic [ADDR_W-1:0] diff;
    diff = last - first;
    return {1'b0, diff} + {{ADDR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_byte_sel.sv
// Combinational 16:1 byte mux over the flat memory bus.
module mem_byte_sel
  import mem_reader_pkg::*;
(
  input  logic [MEM_W-1:0]  bus,
  input  logic [ADDR_W-1:0] idx,
  output logic [WORD_W-1:0] word
);

  // Pick word idx; word k lives at bus[k*WORD_W +: WORD_W].
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx == k[ADDR_W-1:0]) begin
        word = bus[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/mem_reader.sv
// Streams an inclusive, wrapping address range of a snapshotted 16x8 memory
// out over a valid/ready byte interface, then pulses done.
module mem_reader
  import mem_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MEM_W-1:0]  memory,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic [MEM_W-1:0]  snap_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [WORD_W-1:0] sel_word;
  logic              fire;
  logic              load;

  // A beat transfers only while streaming; out_ready never reaches the data path.
  assign fire = (state_q == STREAM) && out_ready;
  assign load = (state_q == IDLE) && start;

  mem_byte_sel u_sel (
    .bus  (snap_q),
    .idx  (cur_addr_q),
    .word (sel_word)
  );

  // State register; reset abandons any dump in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start outside IDLE is dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (fire && (remaining_q == REM_ONE)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot and address/count bookkeeping; the snapshot isolates the dump
  // from executor writes that land while it is streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q      <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else if (load) begin
      snap_q      <= memory;
      cur_addr_q  <= first_addr;
      remaining_q <= range_len(first_addr, last_addr);
    end else if (fire) begin
      cur_addr_q  <= cur_addr_q + ADDR_ONE;
      remaining_q <= remaining_q - REM_ONE;
    end
  end

  // Outputs decoded from registered state only; data is zero outside STREAM.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    if (state_q == STREAM) begin
      out_valid = 1'b1;
      out_data  = sel_word;
      out_addr  = cur_addr_q;
    end
  end

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: stimulus pushes expected beats, a
// negedge monitor pops and compares on every handshake.
module tb_mem_reader;
  import mem_reader_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [MEM_W-1:0]  memory;
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [WORD_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  logic [7:0]  img [16];
  logic [11:0] exp_q [$];
  logic        stall_pend = 1'b0;
  logic [11:0] stall_val;

  always #5 clk = ~clk;

  mem_reader dut (
    .clk        (clk),
    .rst        (rst),
    .memory     (memory),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted beat and check stability under stall.
  always @(negedge clk) begin
    logic [11:0] e;
    if (done) done_seen++;
    if (!rst && out_valid) begin
      if (stall_pend) chk("stall_hold", {20'd0, out_addr, out_data}, {20'd0, stall_val});
      if (out_ready) begin
        stall_pend = 1'b0;
        if (exp_q.size() == 0) begin
          chk("extra_beat", {20'd0, out_addr, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {20'd0, out_addr, out_data}, {20'd0, e});
        end
      end else begin
        stall_pend = 1'b1;
        stall_val  = {out_addr, out_data};
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [7:0] v);
    img[k] = v;
    memory[k*8 +: 8] = v;
  endtask

  task automatic push_range(input int f, input int l);
    int n;
    int a;
    n = ((l - f) & 15) + 1;
    a = f;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a[3:0], img[a]});
      a = (a + 1) & 15;
    end
  endtask

  task automatic issue(input int f, input int l);
    first_addr = f[3:0];
    last_addr  = l[3:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles after the start edge until done is seen, then realigns
  // to just after the following clock edge.
  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc >= maxc) begin
        chk("done_timeout", cyc, 0);
        break;
      end
    end
    tick();
  endtask

  initial begin
    int cyc;
    int d0;
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
    out_ready = 1'b1; memory = '0;
    for (int k = 0; k < 16; k++) set_word(k, 8'h10 + 8'(k));
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_addr",  out_addr, 0);
    rst = 1'b0;
    tick();

    // Full dump 0..15
    d0 = done_seen;
    push_range(0, 15);
    issue(0, 15);
    wait_done(40, cyc);
    chk("full_done_cycle", cyc, 17);
    chk("full_busy_fall", busy, 0);
    chk("full_valid_low", out_valid, 0);
    chk("full_drained", exp_q.size(), 0);
    chk("full_done_cnt", done_seen - d0, 1);

    // Wrap 14..1
    d0 = done_seen;
    push_range(14, 1);
    issue(14, 1);
    wait_done(20, cyc);
    chk("wrap_done_cycle", cyc, 5);
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_done_cnt", done_seen - d0, 1);

    // Single byte 5..5
    set_word(5, 8'hA5);
    push_range(5, 5);
    issue(5, 5);
    wait_done(20, cyc);
    chk("single_done_cycle", cyc, 2);
    chk("single_drained", exp_q.size(), 0);

    // Backpressure on 2..4
    d0 = done_seen;
    push_range(2, 4);
    issue(2, 4);
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      if (i < 5) tick();
    end
    wait_done(20, cyc);
    out_ready = 1'b1;
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_done_cnt", done_seen - d0, 1);

    // Snapshot isolation on 0..7
    set_word(3, 8'h33);
    push_range(0, 7);
    issue(0, 7);
    memory[3*8 +: 8] = 8'hFF;
    wait_done(30, cyc);
    chk("snap_drained", exp_q.size(), 0);
    memory[3*8 +: 8] = 8'h33;

    // Ignored start mid-stream and during DONE
    d0 = done_seen;
    push_range(0, 7);
    issue(0, 7);
    tick(); tick();
    first_addr = 4'd9; last_addr = 4'd10; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc >= 30) begin
        chk("ign_timeout", cyc, 0);
        break;
      end
    end
    first_addr = 4'd12; last_addr = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy_fall", busy, 0);
    chk("ign_valid_low", out_valid, 0);
    tick(); tick(); tick();
    chk("ign_no_second", busy, 0);
    chk("ign_drained", exp_q.size(), 0);
    chk("ign_done_cnt", done_seen - d0, 1);

    // Reset after 3 of 8 beats
    d0 = done_seen;
    push_range(0, 7);
    issue(0, 7);
    tick(); tick(); tick();
    chk("rst_mid_left", exp_q.size(), 5);
    rst = 1'b1;
    tick();
    chk("rstm_valid", out_valid, 0);
    chk("rstm_busy",  busy, 0);
    chk("rstm_done",  done, 0);
    chk("rstm_data",  out_data, 0);
    chk("rstm_addr",  out_addr, 0);
    rst = 1'b0;
    exp_q.delete();
    tick(); tick();
    chk("rstm_no_done", done_seen - d0, 0);
    push_range(4, 6);
    issue(4, 6);
    wait_done(20, cyc);
    chk("rstm_fresh_cycle", cyc, 4);
    chk("rstm_fresh_drained", exp_q.size(), 0);
    chk("rstm_fresh_done", done_seen - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
